// File: rtl/spi_axil_txn_scheduler.sv
// Round-robin scheduler that shares one AXI4-Lite master between NUM_REQ
// requesters. It runs one transaction at a time: it latches the winner's
// command, pulses the master's init input, and waits for the done strobe
// or a timeout. It then returns a one-cycle ack with error and read data.
module spi_axil_txn_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      init_w_axi_txn,
    output logic                      init_r_axi_txn,
    output logic [ADDR_W-1:0]         user_awaddr,
    output logic [ADDR_W-1:0]         user_araddr,
    output logic [DATA_W-1:0]         user_wdata,
    input  logic [DATA_W-1:0]         user_rdata,
    input  logic                      done_w_axi_txn,
    input  logic                      done_r_axi_txn,
    input  logic                      error_w_axi_txn,
    input  logic                      error_r_axi_txn,
    output logic                      busy,
    output logic                      timeout_sticky,
    input  logic                      clr_timeout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // A zero timeout still needs a one-bit timer so that the declarations stay legal.
    // In that case the timer is never advanced.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       grant;
    logic                we_q;
    logic [TW-1:0]       timer;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                any_req;
    logic [PW-1:0]       next_grant;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                done_hit;
    logic                timeout_hit;
    logic                timeout_set;

    // Round-robin search: the first valid requester at or above rr_ptr, with wrap-around.
    always_comb begin
        int cand;
        any_req    = 1'b0;
        next_grant = '0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_req && req_valid[cand]) begin
                any_req    = 1'b1;
                next_grant = PW'(cand);
            end
        end
    end

    // Select the winning requester's command fields from the packed buses.
    always_comb begin
        sel_we    = req_we[next_grant];
        sel_addr  = req_addr[int'(next_grant)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(next_grant)*DATA_W +: DATA_W];
    end

    // Completion and timeout qualifiers for the WAIT state.
    // Only the done strobe for the granted direction counts.
    always_comb begin
        done_hit    = we_q ? done_w_axi_txn : done_r_axi_txn;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);
        timeout_set = (state == S_WAIT) && !done_hit && timeout_hit;
    end

    // State register.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. When done and the timeout coincide, done wins.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (done_hit || timeout_hit) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Command latch, wait timer, response capture and round-robin pointer.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rr_ptr      <= '0;
            grant       <= '0;
            we_q        <= 1'b0;
            timer       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            user_awaddr <= '0;
            user_araddr <= '0;
            user_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        we_q       <= sel_we;
                        user_wdata <= sel_wdata;
                        if (sel_we) begin
                            user_awaddr <= sel_addr;
                        end else begin
                            user_araddr <= sel_addr;
                        end
                    end
                end
                S_ISSUE: begin
                    timer   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                S_WAIT: begin
                    if (done_hit) begin
                        err_q   <= we_q ? error_w_axi_txn : error_r_axi_txn;
                        rdata_q <= we_q ? '0 : user_rdata;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    if (grant == LAST_IDX) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky timeout flag. A new timeout takes priority over a clear in the same cycle.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            timeout_sticky <= 1'b0;
        end else if (timeout_set) begin
            timeout_sticky <= 1'b1;
        end else if (clr_timeout) begin
            timeout_sticky <= 1'b0;
        end
    end

    // Outputs are decoded from the state, so they drop as soon as reset asserts.
    always_comb begin
        busy           = (state != S_IDLE);
        init_w_axi_txn = (state == S_ISSUE) && we_q;
        init_r_axi_txn = (state == S_ISSUE) && !we_q;
        req_ack        = (state == S_RESP) ? (NUM_REQ'(1) << grant) : '0;
        req_err        = (state == S_RESP) && err_q;
        req_rdata      = (state == S_RESP) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_spi_axil_txn_scheduler.sv
// Directed scoreboard bench for spi_axil_txn_scheduler.
module tb_spi_axil_txn_scheduler;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ack;
    logic             req_err;
    logic [DW-1:0]    req_rdata;
    logic             init_w;
    logic             init_r;
    logic [AW-1:0]    user_awaddr;
    logic [AW-1:0]    user_araddr;
    logic [DW-1:0]    user_wdata;
    logic [DW-1:0]    user_rdata;
    logic             done_w;
    logic             done_r;
    logic             error_w;
    logic             error_r;
    logic             busy;
    logic             timeout_sticky;
    logic             clr_timeout;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    spi_axil_txn_scheduler #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ack(req_ack),
        .req_err(req_err),
        .req_rdata(req_rdata),
        .init_w_axi_txn(init_w),
        .init_r_axi_txn(init_r),
        .user_awaddr(user_awaddr),
        .user_araddr(user_araddr),
        .user_wdata(user_wdata),
        .user_rdata(user_rdata),
        .done_w_axi_txn(done_w),
        .done_r_axi_txn(done_r),
        .error_w_axi_txn(error_w),
        .error_r_axi_txn(error_r),
        .busy(busy),
        .timeout_sticky(timeout_sticky),
        .clr_timeout(clr_timeout)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input int idx, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.idx   = idx;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        req_valid[idx]          = 1'b1;
        req_we[idx]             = we;
        req_addr[idx*AW +: AW]  = addr;
        req_wdata[idx*DW +: DW] = wdata;
    endtask

    // Step until an init pulse appears, then check its direction and the latched command.
    task automatic waitIssue(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n;
        n = 0;
        while (!(init_w || init_r) && n < 10) begin
            step();
            n++;
        end
        checkOutput({tag, "_issue_seen"}, 32'(init_w | init_r), 32'd1);
        checkOutput({tag, "_init_w"}, 32'(init_w), 32'(we));
        checkOutput({tag, "_init_r"}, 32'(init_r), 32'(!we));
        if (we) begin
            checkOutput({tag, "_awaddr"}, user_awaddr, addr);
            checkOutput({tag, "_wdata"}, user_wdata, wdata);
        end else begin
            checkOutput({tag, "_araddr"}, user_araddr, addr);
        end
    endtask

    // Pop the scoreboard and compare it against the ack currently on the outputs.
    task automatic popAndCheck(input string tag);
        exp_t e;
        checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_ack"}, 32'(req_ack), 32'd1 << e.idx);
            checkOutput({tag, "_err"}, 32'(req_err), 32'(e.err));
            checkOutput({tag, "_rdata"}, req_rdata, e.rdata);
        end
    endtask

    // Step until an ack appears (bounded), clearing the master strobes after their cycle.
    task automatic waitAck(input string tag);
        int n;
        n = 0;
        step();
        done_w     = 1'b0;
        done_r     = 1'b0;
        error_w    = 1'b0;
        error_r    = 1'b0;
        user_rdata = 32'h5555_5555;
        while (req_ack == '0 && n < 40) begin
            step();
            n++;
        end
        popAndCheck(tag);
    endtask

    // Sit in WAIT for the given number of cycles, then return the master's done strobe.
    task automatic finishTxn(input string tag, input int delay, input logic is_read,
                             input logic err, input logic [31:0] rdata_in);
        step();
        checkOutput({tag, "_single_pulse"}, {30'd0, init_w, init_r}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            step();
            checkOutput($sformatf("%s_noack_%0d", tag, i), 32'(req_ack), 32'd0);
        end
        if (is_read) begin
            done_r     = 1'b1;
            error_r    = err;
            user_rdata = rdata_in;
        end else begin
            done_w     = 1'b1;
            error_w    = err;
            user_rdata = 32'hBAD0_0000;
        end
        waitAck(tag);
    endtask

    // Release the selected requests during the ack cycle, then check that the outputs cleared.
    task automatic afterAck(input string tag, input logic [NR-1:0] drop);
        req_valid = req_valid & ~drop;
        step();
        checkOutput({tag, "_ack_clear"}, 32'(req_ack), 32'd0);
        checkOutput({tag, "_err_clear"}, 32'(req_err), 32'd0);
        checkOutput({tag, "_rdata_clear"}, req_rdata, 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        user_rdata  = '0;
        done_w      = 1'b0;
        done_r      = 1'b0;
        error_w     = 1'b0;
        error_r     = 1'b0;
        clr_timeout = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ack", 32'(req_ack), 32'd0);
        checkOutput("rst_init", {30'd0, init_w, init_r}, 32'd0);
        checkOutput("rst_awaddr", user_awaddr, 32'd0);
        checkOutput("rst_sticky", 32'(timeout_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Test 1: requester 0 writes; the master's done arrives after three WAIT cycles.
        $display("[TB] single write");
        pushExpect(0, 1'b0, 32'd0);
        applyStimulus(0, 1'b1, 32'h40, 32'hA5A5_0001);
        waitIssue("t1", 1'b1, 32'h40, 32'hA5A5_0001);
        finishTxn("t1", 3, 1'b0, 1'b0, 32'd0);
        afterAck("t1", 2'b01);

        // Test 2: requester 1 reads.
        $display("[TB] single read");
        pushExpect(1, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b0, 32'h80, 32'd0);
        waitIssue("t2", 1'b0, 32'h80, 32'd0);
        finishTxn("t2", 1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        afterAck("t2", 2'b10);

        // Test 3: both requests are held. Grants must alternate 0,1,0,1.
        $display("[TB] round robin");
        applyStimulus(0, 1'b1, 32'h100, 32'hAAAA_0000);
        applyStimulus(1, 1'b0, 32'h200, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pushExpect(i % 2, 1'b0, (i % 2 == 1) ? 32'hC0DE_0000 + 32'(i) : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            waitIssue($sformatf("t3_%0d", i), (i % 2 == 0), (i % 2 == 0) ? 32'h100 : 32'h200,
                      32'hAAAA_0000);
            finishTxn($sformatf("t3_%0d", i), 0, (i % 2 == 1), 1'b0, 32'hC0DE_0000 + 32'(i));
            afterAck($sformatf("t3_%0d", i), (i == 3) ? 2'b11 : 2'b00);
        end

        // Test 4: no done strobe arrives. The timeout fires at WAIT cycle 16.
        $display("[TB] timeout");
        checkOutput("t4_sticky_pre", 32'(timeout_sticky), 32'd0);
        pushExpect(0, 1'b1, 32'd0);
        applyStimulus(0, 1'b0, 32'h300, 32'd0);
        user_rdata = 32'h7777_7777;
        waitIssue("t4", 1'b0, 32'h300, 32'd0);
        step();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            checkOutput($sformatf("t4_wait_%0d", i), {30'd0, req_ack}, 32'd0);
        end
        checkOutput("t4_sticky_in_wait", 32'(timeout_sticky), 32'd0);
        step();
        popAndCheck("t4");
        checkOutput("t4_sticky_set", 32'(timeout_sticky), 32'd1);
        afterAck("t4", 2'b01);
        step();
        checkOutput("t4_sticky_hold", 32'(timeout_sticky), 32'd1);
        clr_timeout = 1'b1;
        step();
        clr_timeout = 1'b0;
        checkOutput("t4_sticky_clr", 32'(timeout_sticky), 32'd0);

        // Test 5: a done_w pulse during a read is ignored; the read then completes with an error.
        $display("[TB] read error and foreign done");
        pushExpect(1, 1'b1, 32'h0000_1234);
        applyStimulus(1, 1'b0, 32'h1C0, 32'd0);
        waitIssue("t5", 1'b0, 32'h1C0, 32'd0);
        step();
        done_w  = 1'b1;
        error_w = 1'b1;
        step();
        done_w  = 1'b0;
        error_w = 1'b0;
        checkOutput("t5_foreign_done_ack", 32'(req_ack), 32'd0);
        checkOutput("t5_foreign_done_busy", 32'(busy), 32'd1);
        done_r     = 1'b1;
        error_r    = 1'b1;
        user_rdata = 32'h0000_1234;
        waitAck("t5");
        afterAck("t5", 2'b10);

        // Test 6: move the pointer to 1, abort with reset during WAIT, and check that the pointer returns to 0.
        $display("[TB] reset during wait");
        pushExpect(0, 1'b0, 32'd0);
        applyStimulus(0, 1'b1, 32'h500, 32'h11);
        waitIssue("t6a", 1'b1, 32'h500, 32'h11);
        finishTxn("t6a", 0, 1'b0, 1'b0, 32'd0);
        afterAck("t6a", 2'b01);
        applyStimulus(0, 1'b1, 32'h600, 32'h22);
        applyStimulus(1, 1'b0, 32'h700, 32'd0);
        waitIssue("t6b", 1'b0, 32'h700, 32'd0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_ack", 32'(req_ack), 32'd0);
        checkOutput("t6_rst_init", {30'd0, init_w, init_r}, 32'd0);
        checkOutput("t6_rst_araddr", user_araddr, 32'd0);
        checkOutput("t6_rst_awaddr", user_awaddr, 32'd0);
        checkOutput("t6_rst_wdata", user_wdata, 32'd0);
        checkOutput("t6_rst_err", 32'(req_err), 32'd0);
        checkOutput("t6_rst_rdata", req_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pushExpect(0, 1'b0, 32'd0);
        waitIssue("t6c", 1'b1, 32'h600, 32'h22);
        finishTxn("t6c", 0, 1'b0, 1'b0, 32'd0);
        afterAck("t6c", 2'b11);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
